mux_nto1_rr: RTL and testbench
==============================

// Module: mux_nto1_rr
// PURPOSE
//  Parametrised N:1 registered data multiplexer for the Tx datapath. Selects one of CHANNELS
//  WIDTH-bit lanes, either by an external selector or by internal round-robin over valid lanes.
//  Output stage is a one-deep register with valid/ready backpressure and a per-lane ack.
//  Sits between the per-lane FIFOs and the byte-striping/serialiser stage.
// PARAMETERS
//  WIDTH     8  data bits per lane
//  CHANNELS  4  number of input lanes, >=2, need not be a power of 2
//  SEL_W     2  selector width, must be >= ceil(log2(CHANNELS))
// PORTS
//  clk        in   1                 rising-edge clock
//  reset_L    in   1                 async active-low reset
//  mode_rr    in   1                 0 = external select, 1 = round-robin
//  ext_sel    in   SEL_W             lane index used when mode_rr=0
//  data_in    in   CHANNELS*WIDTH    lane k at [k*WIDTH +: WIDTH]
//  valid_in   in   CHANNELS          lane k has data
//  ready_in   in   1                 downstream accepts data_out this cycle
//  ack_out    out  CHANNELS          one-hot comb.; lane k consumed this cycle
//  data_out   out  WIDTH             registered selected data
//  valid_out  out  1                 registered; data_out meaningful
//  sel_out    out  SEL_W             registered index of lane held in data_out
// BEHAVIOUR
//  - reset_L=0 (any time, async): data_out=0, valid_out=0, sel_out=0, rr pointer=0, ack_out=0.
//  - accept = ready_in | ~valid_out. No accept -> data_out/valid_out/sel_out hold, ack_out=0.
//  - Latency 1 cycle: lane sampled at edge N appears on data_out after edge N.
//  - mode_rr=0: on accept, data_out<=lane[ext_sel], valid_out<=valid_in[ext_sel],
//    sel_out<=ext_sel; ack_out[ext_sel]=valid_in[ext_sel]&accept.
//    ext_sel>=CHANNELS: treated as idle lane (valid_out<=0, data_out holds, ack_out=0).
//  - mode_rr=1: grant = first k with valid_in[k], searched ptr, ptr+1, .. CHANNELS-1, 0, ..
//    ptr-1. On accept with a grant: load lane, sel_out<=grant, ack_out=onehot(grant),
//    ptr<=(grant==CHANNELS-1)?0:grant+1. No valid lane: valid_out<=0, ptr and data hold.
//  - Lanes must hold data and valid until acked; ack_out never asserts without accept.
//  - At most one ack_out bit high per cycle; ack_out=0 while reset_L=0.
//  - mode_rr change takes effect at next accept; ptr is not cleared by mode change and
//    does not move in mode_rr=0.
//  - Simultaneous load and drain (valid_out=1, ready_in=1): new word loads, no bubble;
//    full throughput of one word per cycle.
// STRUCTURE
//  - Shared header mux_defines.vh: MODE_EXT=1'b0, MODE_RR=1'b1 constants and the
//    lane-slice macro; reused by other Tx muxes.
//  - One sub-module rr_arbiter (CHANNELS, SEL_W): inputs req, ptr; outputs grant index,
//    grant_valid; purely combinational. Top holds ptr, output register and ack logic.
// TESTING
//  1 Reset: drive reset_L=0 mid-stream with valid_out=1 -> all outputs 0 same cycle,
//    ptr=0 after release.
//  2 Ext mode, CHANNELS=4: ext_sel=2, lane2=8'hA5 valid, ready_in=1 -> next cycle
//    data_out=A5, valid_out=1, sel_out=2, ack_out=4'b0100 in sampling cycle.
//  3 RR fairness: all 4 lanes valid continuously, ready_in=1 -> sel_out sequence
//    0,1,2,3,0; each lane acked once per 4 cycles.
//  4 RR skip/wrap: CHANNELS=3, ptr=2, valid_in=3'b001 -> grant 0, ptr becomes 1;
//    valid_in=0 -> valid_out=0, ptr stays 1.
//  5 Backpressure: valid_out=1, ready_in=0 for 3 cycles -> data_out/sel_out stable,
//    ack_out=0; ready_in=1 -> next word loads same edge, no bubble.
//  6 Edge select: ext_sel=3 with CHANNELS=3 -> valid_out=0, ack_out=0.

Source files
------------

// File: rtl/mux_nto1_rr_pkg.sv
// Shared constants for the Tx datapath multiplexers.
// MODE_EXT / MODE_RR encode the mode_rr input of the N:1 muxes.
package mux_nto1_rr_pkg;

  localparam logic MODE_EXT = 1'b0;
  localparam logic MODE_RR  = 1'b1;

endpackage

// File: rtl/mux_nto1_rr_arbiter.sv
// Purely combinational round-robin arbiter.
// Ports:
//   i_req         per-lane request vector
//   i_ptr         lane index with highest priority this cycle (must be < CHANNELS)
//   o_grant       index of the first requesting lane at or after i_ptr, wrapping
//   o_grant_valid at least one lane is requesting
module mux_nto1_rr_arbiter #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SEL_W    = 2
) (
  input  logic [CHANNELS-1:0] i_req,
  input  logic [SEL_W-1:0]    i_ptr,
  output logic [SEL_W-1:0]    o_grant,
  output logic                o_grant_valid
);

  logic             w_hi_found;
  logic             w_lo_found;
  logic [SEL_W-1:0] w_hi_idx;
  logic [SEL_W-1:0] w_lo_idx;

  // Two ascending scans: the first request at or above the pointer wins; otherwise the wrap
  // around falls back to the lowest requesting lane overall.
  always_comb begin
    w_hi_found = 1'b0;
    w_lo_found = 1'b0;
    w_hi_idx   = '0;
    w_lo_idx   = '0;
    for (int k = 0; k < int'(CHANNELS); k++) begin
      if (i_req[k]) begin
        if (!w_lo_found) begin
          w_lo_found = 1'b1;
          w_lo_idx   = SEL_W'(k);
        end
        if (!w_hi_found && (SEL_W'(k) >= i_ptr)) begin
          w_hi_found = 1'b1;
          w_hi_idx   = SEL_W'(k);
        end
      end
    end
  end

  assign o_grant       = w_hi_found ? w_hi_idx : w_lo_idx;
  assign o_grant_valid = w_lo_found;

endmodule

// File: rtl/mux_nto1_rr.sv
// N:1 registered lane multiplexer for the Tx datapath.
// Picks one of CHANNELS WIDTH-bit lanes by external select or by round-robin over valid lanes,
// and holds it in a one-deep output register with valid/ready handshake.
// Ports:
//   clk, reset_L  rising-edge clock, asynchronous active-low reset
//   mode_rr       0 = external select (ext_sel), 1 = round-robin
//   ext_sel       lane index used in external mode
//   data_in       lane k at [k*WIDTH +: WIDTH]
//   valid_in      per-lane valid
//   ready_in      downstream takes data_out this cycle
//   ack_out       one-hot, combinational: lane consumed this cycle
//   data_out      registered selected data
//   valid_out     registered valid for data_out
//   sel_out       registered index of the lane held in data_out
module mux_nto1_rr
  import mux_nto1_rr_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      reset_L,
  input  logic                      mode_rr,
  input  logic [SEL_W-1:0]          ext_sel,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic [CHANNELS-1:0]       valid_in,
  input  logic                      ready_in,
  output logic [CHANNELS-1:0]       ack_out,
  output logic [WIDTH-1:0]          data_out,
  output logic                      valid_out,
  output logic [SEL_W-1:0]          sel_out
);

  logic [WIDTH-1:0]    r_data_q, r_data_d;
  logic                r_valid_q, r_valid_d;
  logic [SEL_W-1:0]    r_sel_q, r_sel_d;
  logic [SEL_W-1:0]    r_ptr_q, r_ptr_d;

  logic                w_accept;
  logic [SEL_W-1:0]    w_grant;
  logic                w_grant_valid;
  logic                w_ext_ok;
  logic                w_ext_valid;
  logic [WIDTH-1:0]    w_ext_data;
  logic [CHANNELS-1:0] w_ext_onehot;
  logic [WIDTH-1:0]    w_gnt_data;
  logic [CHANNELS-1:0] w_gnt_onehot;
  logic [CHANNELS-1:0] w_ack;

  mux_nto1_rr_arbiter #(
    .CHANNELS (CHANNELS),
    .SEL_W    (SEL_W)
  ) u_arbiter (
    .i_req         (valid_in),
    .i_ptr         (r_ptr_q),
    .o_grant       (w_grant),
    .o_grant_valid (w_grant_valid)
  );

  // Register is free when empty or being drained; allows load and drain in the same cycle.
  assign w_accept = ready_in | ~r_valid_q;

  // Lane selection by compare rather than variable slice, so an out-of-range ext_sel simply
  // matches nothing and reads as an idle lane.
  always_comb begin
    w_ext_ok     = 1'b0;
    w_ext_valid  = 1'b0;
    w_ext_data   = '0;
    w_ext_onehot = '0;
    w_gnt_data   = '0;
    w_gnt_onehot = '0;
    for (int k = 0; k < int'(CHANNELS); k++) begin
      if (ext_sel == SEL_W'(k)) begin
        w_ext_ok        = 1'b1;
        w_ext_valid     = valid_in[k];
        w_ext_data      = data_in[k*WIDTH +: WIDTH];
        w_ext_onehot[k] = 1'b1;
      end
      if (w_grant == SEL_W'(k)) begin
        w_gnt_data      = data_in[k*WIDTH +: WIDTH];
        w_gnt_onehot[k] = 1'b1;
      end
    end
  end

  always_comb begin
    r_data_d  = r_data_q;
    r_valid_d = r_valid_q;
    r_sel_d   = r_sel_q;
    r_ptr_d   = r_ptr_q;
    w_ack     = '0;
    if (w_accept) begin
      if (mode_rr == MODE_EXT) begin
        if (w_ext_ok) begin
          r_data_d  = w_ext_data;
          r_valid_d = w_ext_valid;
          r_sel_d   = ext_sel;
          if (w_ext_valid) begin
            w_ack = w_ext_onehot;
          end
        end else begin
          r_valid_d = 1'b0;
        end
      end else begin
        if (w_grant_valid) begin
          r_data_d  = w_gnt_data;
          r_valid_d = 1'b1;
          r_sel_d   = w_grant;
          w_ack     = w_gnt_onehot;
          r_ptr_d   = (w_grant == SEL_W'(CHANNELS - 1)) ? '0 : w_grant + 1'b1;
        end else begin
          r_valid_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_data_q  <= '0;
      r_valid_q <= 1'b0;
      r_sel_q   <= '0;
      r_ptr_q   <= '0;
    end else begin
      r_data_q  <= r_data_d;
      r_valid_q <= r_valid_d;
      r_sel_q   <= r_sel_d;
      r_ptr_q   <= r_ptr_d;
    end
  end

  // Empty register makes accept true during reset; keep lanes from seeing a spurious ack.
  assign ack_out   = w_ack & {CHANNELS{reset_L}};
  assign data_out  = r_data_q;
  assign valid_out = r_valid_q;
  assign sel_out   = r_sel_q;

endmodule

// File: tb/tb_mux_nto1_rr.sv
module tb_mux_nto1_rr;

  logic clk = 1'b0;
  logic reset_L = 1'b0;
  always #5 clk = ~clk;

  // Four-lane instance
  logic        mode4, rdy4;
  logic [1:0]  sel4_i;
  logic [31:0] din4;
  logic [3:0]  vin4, ack4;
  logic [7:0]  dout4;
  logic        vout4;
  logic [1:0]  sel4;

  // Three-lane instance
  logic        mode3, rdy3;
  logic [1:0]  sel3_i;
  logic [23:0] din3;
  logic [2:0]  vin3, ack3;
  logic [7:0]  dout3;
  logic        vout3;
  logic [1:0]  sel3;

  mux_nto1_rr #(.WIDTH(8), .CHANNELS(4), .SEL_W(2)) u_dut4 (
    .clk(clk), .reset_L(reset_L), .mode_rr(mode4), .ext_sel(sel4_i), .data_in(din4),
    .valid_in(vin4), .ready_in(rdy4), .ack_out(ack4), .data_out(dout4), .valid_out(vout4),
    .sel_out(sel4)
  );

  mux_nto1_rr #(.WIDTH(8), .CHANNELS(3), .SEL_W(2)) u_dut3 (
    .clk(clk), .reset_L(reset_L), .mode_rr(mode3), .ext_sel(sel3_i), .data_in(din3),
    .valid_in(vin3), .ready_in(rdy3), .ack_out(ack3), .data_out(dout3), .valid_out(vout3),
    .sel_out(sel3)
  );

  typedef struct {
    bit          d3;
    bit          mode;
    logic [1:0]  sel;
    logic [31:0] data;
    logic [3:0]  vin;
    bit          rdy;
    logic [3:0]  e_ack;
    logic [7:0]  e_data;
    bit          e_valid;
    logic [1:0]  e_sel;
    bit          chk_sel;
  } vec_t;

  typedef struct {
    bit         d3;
    int         idx;
    logic [7:0] data;
    bit         valid;
    logic [1:0] sel;
    bit         chk_sel;
  } exp_t;

  vec_t vq[$];
  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  localparam logic [31:0] D4 = 32'h4433_2211;
  localparam logic [31:0] D3 = 32'h00CC_BBAA;

  function automatic vec_t mk(bit d3, bit mode, logic [1:0] sel, logic [31:0] data,
                              logic [3:0] vin, bit rdy, logic [3:0] e_ack, logic [7:0] e_data,
                              bit e_valid, logic [1:0] e_sel, bit chk_sel);
    vec_t v;
    v.d3 = d3; v.mode = mode; v.sel = sel; v.data = data; v.vin = vin; v.rdy = rdy;
    v.e_ack = e_ack; v.e_data = e_data; v.e_valid = e_valid; v.e_sel = e_sel;
    v.chk_sel = chk_sel;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic idle4();
    mode4 = 1'b0; sel4_i = 2'd0; vin4 = '0; rdy4 = 1'b1;
  endtask

  task automatic idle3();
    mode3 = 1'b0; sel3_i = 2'd0; vin3 = '0; rdy3 = 1'b1; din3 = '0;
  endtask

  task automatic drive(input vec_t v);
    if (v.d3) begin
      idle4();
      mode3 = v.mode; sel3_i = v.sel; din3 = v.data[23:0]; vin3 = v.vin[2:0]; rdy3 = v.rdy;
    end else begin
      idle3();
      mode4 = v.mode; sel4_i = v.sel; din4 = v.data; vin4 = v.vin; rdy4 = v.rdy;
    end
  endtask

  vec_t v;
  exp_t e;

  initial begin
    // Ext mode, backpressure, out-of-range-free edge select on 4 lanes
    vq.push_back(mk(0, 0, 2, 32'h00A5_0000, 4'b0100, 1, 4'b0100, 8'hA5, 1, 2, 1));
    vq.push_back(mk(0, 0, 1, D4, 4'b1111, 0, 4'b0000, 8'hA5, 1, 2, 1));
    vq.push_back(mk(0, 0, 1, D4, 4'b1111, 0, 4'b0000, 8'hA5, 1, 2, 1));
    vq.push_back(mk(0, 0, 1, D4, 4'b1111, 0, 4'b0000, 8'hA5, 1, 2, 1));
    vq.push_back(mk(0, 0, 1, D4, 4'b1111, 1, 4'b0010, 8'h22, 1, 1, 1));
    vq.push_back(mk(0, 0, 0, D4, 4'b1111, 1, 4'b0001, 8'h11, 1, 0, 1));
    vq.push_back(mk(0, 0, 3, D4, 4'b0111, 1, 4'b0000, 8'h44, 0, 3, 1));
    vq.push_back(mk(0, 0, 3, D4, 4'b1111, 0, 4'b1000, 8'h44, 1, 3, 1));
    // Round-robin fairness from ptr 0 (ext mode must not have moved it)
    vq.push_back(mk(0, 1, 0, D4, 4'b1111, 1, 4'b0001, 8'h11, 1, 0, 1));
    vq.push_back(mk(0, 1, 0, D4, 4'b1111, 1, 4'b0010, 8'h22, 1, 1, 1));
    vq.push_back(mk(0, 1, 0, D4, 4'b1111, 1, 4'b0100, 8'h33, 1, 2, 1));
    vq.push_back(mk(0, 1, 0, D4, 4'b1111, 1, 4'b1000, 8'h44, 1, 3, 1));
    vq.push_back(mk(0, 1, 0, D4, 4'b1111, 1, 4'b0001, 8'h11, 1, 0, 1));
    // No valid lane, then wrap search from ptr 1, then stall in rr mode
    vq.push_back(mk(0, 1, 0, D4, 4'b0000, 1, 4'b0000, 8'h11, 0, 0, 0));
    vq.push_back(mk(0, 1, 0, D4, 4'b0001, 1, 4'b0001, 8'h11, 1, 0, 1));
    vq.push_back(mk(0, 1, 0, D4, 4'b1001, 0, 4'b0000, 8'h11, 1, 0, 1));
    vq.push_back(mk(0, 1, 0, D4, 4'b1001, 1, 4'b1000, 8'h44, 1, 3, 1));
    // Mode switch: ptr left at 0 and unchanged by ext mode
    vq.push_back(mk(0, 0, 2, D4, 4'b0100, 1, 4'b0100, 8'h33, 1, 2, 1));
    vq.push_back(mk(0, 1, 0, D4, 4'b1111, 1, 4'b0001, 8'h11, 1, 0, 1));
    // Three lanes: skip/wrap and out-of-range select
    vq.push_back(mk(1, 1, 0, D3, 4'b0011, 1, 4'b0001, 8'hAA, 1, 0, 1));
    vq.push_back(mk(1, 1, 0, D3, 4'b0011, 1, 4'b0010, 8'hBB, 1, 1, 1));
    vq.push_back(mk(1, 1, 0, D3, 4'b0001, 1, 4'b0001, 8'hAA, 1, 0, 1));
    vq.push_back(mk(1, 1, 0, D3, 4'b0000, 1, 4'b0000, 8'hAA, 0, 0, 0));
    vq.push_back(mk(1, 1, 0, D3, 4'b0111, 1, 4'b0010, 8'hBB, 1, 1, 1));
    vq.push_back(mk(1, 0, 3, D3, 4'b0111, 1, 4'b0000, 8'hBB, 0, 0, 0));
    vq.push_back(mk(1, 0, 2, D3, 4'b0111, 1, 4'b0100, 8'hCC, 1, 2, 1));

    // Reset state, with lanes valid to show ack is held low during reset
    din4 = D4; idle3(); mode4 = 1'b0; sel4_i = 2'd1; vin4 = 4'b1111; rdy4 = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_ack4", 0, 32'(ack4), 32'h0);
    check("rst_valid4", 0, 32'(vout4), 32'h0);
    check("rst_data4", 0, 32'(dout4), 32'h0);
    check("rst_sel4", 0, 32'(sel4), 32'h0);
    check("rst_valid3", 0, 32'(vout3), 32'h0);
    idle4();
    #1 reset_L = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      @(negedge clk);
      drive(v);
      #1;
      check("ack", i, v.d3 ? {28'h0, 1'b0, ack3} : {28'h0, ack4}, 32'(v.e_ack));
      e.d3 = v.d3; e.idx = i; e.data = v.e_data; e.valid = v.e_valid;
      e.sel = v.e_sel; e.chk_sel = v.chk_sel;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check("data_out", e.idx, 32'(e.d3 ? dout3 : dout4), 32'(e.data));
      check("valid_out", e.idx, 32'(e.d3 ? vout3 : vout4), 32'(e.valid));
      if (e.chk_sel) check("sel_out", e.idx, 32'(e.d3 ? sel3 : sel4), 32'(e.sel));
    end

    // Mid-stream reset: valid_out=1, ptr non-zero; outputs clear at once, ptr restarts at 0
    @(negedge clk);
    idle3(); din4 = D4; mode4 = 1'b1; vin4 = 4'b1111; rdy4 = 1'b1;
    @(posedge clk);
    #1;
    check("pre_rst_valid", 0, 32'(vout4), 32'h1);
    check("pre_rst_sel", 0, 32'(sel4), 32'h1);
    @(negedge clk);
    #2 reset_L = 1'b0;
    #1;
    check("mid_rst_data", 0, 32'(dout4), 32'h0);
    check("mid_rst_valid", 0, 32'(vout4), 32'h0);
    check("mid_rst_sel", 0, 32'(sel4), 32'h0);
    check("mid_rst_ack", 0, 32'(ack4), 32'h0);
    #1 reset_L = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_sel", 0, 32'(sel4), 32'h0);
    check("post_rst_data", 0, 32'(dout4), 32'h11);
    @(posedge clk);
    #1;
    check("post_rst_sel", 1, 32'(sel4), 32'h1);
    check("post_rst_data", 1, 32'(dout4), 32'h22);

    check("sb_empty", 0, 32'(sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
